// File: rtl/sfu_pair_gen_pkg.sv
// Shared types and constants for the SFU-check pair producer and its consumer.
package sfu_pair_gen_pkg;

    localparam int LABEL_W = 3;

    typedef logic [LABEL_W-1:0] label_t;

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic int num_pairs(input int n);
        return n * (n - 1) / 2;
    endfunction

    localparam int NUM_PAIRS = num_pairs(8);

endpackage

// File: rtl/sfu_pair_index_counter.sv
// Nested (i,j) counter walking every unordered pair i<j, one pair per step.
module sfu_pair_index_counter #(
    parameter int NUM_ANT     = 8,
    parameter int LABEL_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   step,
    output logic [LABEL_WIDTH-1:0] i,
    output logic [LABEL_WIDTH-1:0] j,
    output logic                   last
);

    localparam logic [LABEL_WIDTH-1:0] I_LAST = LABEL_WIDTH'(NUM_ANT - 2);
    localparam logic [LABEL_WIDTH-1:0] J_LAST = LABEL_WIDTH'(NUM_ANT - 1);

    assign last = (i == I_LAST) && (j == J_LAST);

    always_ff @(posedge clk) begin
        if (!rst || start) begin
            i <= '0;
            j <= LABEL_WIDTH'(1);
        end else if (step) begin
            if (last) begin
                i <= '0;
                j <= LABEL_WIDTH'(1);
            end else if (j == J_LAST) begin
                // row done: next row starts just right of the new diagonal
                i <= i + LABEL_WIDTH'(1);
                j <= i + LABEL_WIDTH'(2);
            end else begin
                j <= j + LABEL_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/sfu_pair_gen.sv
// Buffers one frame of antenna metrics, then streams every (i<j) pair to SFU-check.
module sfu_pair_gen
    import sfu_pair_gen_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int LABEL_WIDTH = 3,
    parameter int NUM_ANT     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   in_ready,
    output logic                   x_valid,
    output logic [DATA_WIDTH-1:0]  x_0,
    output logic [DATA_WIDTH-1:0]  x_1,
    output logic [LABEL_WIDTH-1:0] x_label_0,
    output logic [LABEL_WIDTH-1:0] x_label_1,
    output logic                   x_last,
    output logic                   busy
);

    localparam logic [LABEL_WIDTH-1:0] CNT_LAST = LABEL_WIDTH'(NUM_ANT - 1);

    logic [DATA_WIDTH-1:0]  mem [NUM_ANT];
    state_t                 state;
    logic [LABEL_WIDTH-1:0] count;
    logic [LABEL_WIDTH-1:0] pi;
    logic [LABEL_WIDTH-1:0] pj;
    logic                   pair_last;
    logic                   accept;
    logic                   accept_last;
    logic                   start;
    logic                   step;

    assign accept      = (state == LOAD) && in_valid;
    assign accept_last = accept && (count == CNT_LAST);
    // the first pair is issued on the very edge that completes the frame
    assign step        = (state == EMIT) || accept_last;
    assign start       = (state == LOAD) && !accept_last;

    sfu_pair_index_counter #(
        .NUM_ANT     (NUM_ANT),
        .LABEL_WIDTH (LABEL_WIDTH)
    ) u_idx (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .step  (step),
        .i     (pi),
        .j     (pj),
        .last  (pair_last)
    );

    always_ff @(posedge clk) begin
        if (rst && accept) mem[count] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= LOAD;
            count     <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            x_valid   <= 1'b0;
            x_last    <= 1'b0;
            x_0       <= '0;
            x_1       <= '0;
            x_label_0 <= '0;
            x_label_1 <= '0;
        end else begin
            x_valid <= 1'b0;
            x_last  <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept_last) begin
                        count     <= '0;
                        x_valid   <= 1'b1;
                        x_last    <= pair_last;
                        x_0       <= mem[pi];
                        // the final sample is still in flight, bypass it
                        x_1       <= (pj == count) ? in_data : mem[pj];
                        x_label_0 <= pi;
                        x_label_1 <= pj;
                        if (!pair_last) begin
                            state    <= EMIT;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end else if (accept) begin
                        count <= count + LABEL_WIDTH'(1);
                    end
                end
                EMIT: begin
                    x_valid   <= 1'b1;
                    x_last    <= pair_last;
                    x_0       <= mem[pi];
                    x_1       <= mem[pj];
                    x_label_0 <= pi;
                    x_label_1 <= pj;
                    if (pair_last) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_sfu_pair_gen.sv
// Frame-level bench: table of frames plus random frames, pairs checked against a pair-list model.
module tb_sfu_pair_gen;
    import sfu_pair_gen_pkg::*;

    typedef logic [7:0][7:0] frame_t;

    typedef struct {
        logic [7:0] x0;
        logic [7:0] x1;
        logic [2:0] l0;
        logic [2:0] l1;
        logic       last;
    } pair_t;

    typedef struct {
        frame_t     d;
        int         gap;
        bit         flood;
        logic [7:0] f0, f1, e0, e1;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, x_valid, x_last, busy;
    logic [7:0] x_0, x_1;
    logic [2:0] x_label_0, x_label_1;

    logic       in_valid2 = 1'b0;
    logic [7:0] in_data2 = '0;
    logic       in_ready2, x_valid2, x_last2, busy2;
    logic [7:0] x_02, x_12;
    logic       x_label_02, x_label_12;

    int tests = 0;
    int fails = 0;
    logic [7:0] obs_f0, obs_f1, obs_e0, obs_e1;

    always #5 clk = ~clk;

    sfu_pair_gen dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .x_valid(x_valid), .x_0(x_0), .x_1(x_1), .x_label_0(x_label_0), .x_label_1(x_label_1),
        .x_last(x_last), .busy(busy)
    );

    sfu_pair_gen #(.DATA_WIDTH(8), .LABEL_WIDTH(1), .NUM_ANT(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
        .x_valid(x_valid2), .x_0(x_02), .x_1(x_12), .x_label_0(x_label_02), .x_label_1(x_label_12),
        .x_last(x_last2), .busy(busy2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic frame_t mk(input int base, input int stp);
        frame_t f;
        for (int k = 0; k < 8; k++) f[k] = 8'(base + k * stp);
        return f;
    endfunction

    // gap: 0 back-to-back, 1 one idle cycle between samples, 2 random idles
    task automatic load_frame(input frame_t d, input int gap);
        for (int k = 0; k < 8; k++) begin
            int ng;
            ng = (gap == 1) ? ((k > 0) ? 1 : 0) : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (ng) begin
                @(negedge clk);
                chk("load_idle_x_valid", x_valid, 0);
                chk("load_idle_in_ready", in_ready, 1);
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
            @(negedge clk);
            chk("load_x_valid", x_valid, 0);
            chk("load_in_ready", in_ready, 1);
            chk("load_busy", busy, 0);
            in_valid = 1'b1;
            in_data  = d[k];
        end
    endtask

    task automatic emit_check(input frame_t d, input bit flood, input int stop);
        pair_t q[$];
        pair_t e;
        for (int a = 0; a < 8; a++)
            for (int b = a + 1; b < 8; b++)
                q.push_back('{d[a], d[b], 3'(a), 3'(b), (a == 6 && b == 7)});
        for (int p = 0; p < stop; p++) begin
            @(negedge clk);
            e = q[p];
            chk($sformatf("p%0d_x_valid", p), x_valid, 1);
            chk($sformatf("p%0d_x_0", p), x_0, e.x0);
            chk($sformatf("p%0d_x_1", p), x_1, e.x1);
            chk($sformatf("p%0d_label_0", p), x_label_0, e.l0);
            chk($sformatf("p%0d_label_1", p), x_label_1, e.l1);
            chk($sformatf("p%0d_x_last", p), x_last, e.last);
            if (p < NUM_PAIRS - 1) begin
                chk($sformatf("p%0d_busy", p), busy, 1);
                chk($sformatf("p%0d_in_ready", p), in_ready, 0);
            end
            if (p == 0) begin obs_f0 = x_0; obs_f1 = x_1; end
            if (p == NUM_PAIRS - 1) begin obs_e0 = x_0; obs_e1 = x_1; end
            in_valid = flood && (p < NUM_PAIRS - 1);
            in_data  = 8'hFF;
        end
        in_valid = 1'b0;
        if (stop == NUM_PAIRS) begin
            @(negedge clk);
            chk("post_x_valid", x_valid, 0);
            chk("post_x_last", x_last, 0);
            chk("post_in_ready", in_ready, 1);
            chk("post_busy", busy, 0);
            chk("post_hold_x_0", x_0, e.x0);
            chk("post_hold_x_1", x_1, e.x1);
            chk("post_hold_label_1", x_label_1, e.l1);
        end
    endtask

    initial begin
        vec_t  vecs[5];
        frame_t fr;

        vecs[0] = '{mk(10, 10), 0, 1'b0, 8'd10, 8'd20, 8'd70, 8'd80};
        vecs[1] = '{mk(8'h11, 8'h11), 1, 1'b0, 8'h11, 8'h22, 8'h77, 8'h88};
        vecs[2] = '{mk(8'hA0, 1), 0, 1'b1, 8'hA0, 8'hA1, 8'hA6, 8'hA7};
        vecs[3] = '{mk(1, 1), 0, 1'b0, 8'd1, 8'd2, 8'd7, 8'd8};
        vecs[4] = '{mk(9, 1), 0, 1'b0, 8'd9, 8'd10, 8'd15, 8'd16};

        repeat (3) @(negedge clk);
        chk("rst_x_valid", x_valid, 0);
        chk("rst_x_last", x_last, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_x_0", x_0, 0);
        chk("rst_x_1", x_1, 0);
        chk("rst_label_1", x_label_1, 0);
        rst = 1'b1;

        // two-antenna build: a single pair that is also the last
        @(negedge clk);
        in_valid2 = 1'b1; in_data2 = 8'h5A;
        @(negedge clk);
        chk("n2_x_valid_early", x_valid2, 0);
        in_data2 = 8'hC3;
        @(negedge clk);
        in_valid2 = 1'b0;
        chk("n2_x_valid", x_valid2, 1);
        chk("n2_x_last", x_last2, 1);
        chk("n2_x_0", x_02, 8'h5A);
        chk("n2_x_1", x_12, 8'hC3);
        chk("n2_label_0", x_label_02, 0);
        chk("n2_label_1", x_label_12, 1);
        @(negedge clk);
        chk("n2_post_x_valid", x_valid2, 0);
        chk("n2_post_x_last", x_last2, 0);
        chk("n2_post_in_ready", in_ready2, 1);
        chk("n2_busy", busy2, 0);

        for (int v = 0; v < 5; v++) begin
            load_frame(vecs[v].d, vecs[v].gap);
            emit_check(vecs[v].d, vecs[v].flood, NUM_PAIRS);
            chk($sformatf("vec%0d_first_x_0", v), obs_f0, vecs[v].f0);
            chk($sformatf("vec%0d_first_x_1", v), obs_f1, vecs[v].f1);
            chk($sformatf("vec%0d_last_x_0", v), obs_e0, vecs[v].e0);
            chk($sformatf("vec%0d_last_x_1", v), obs_e1, vecs[v].e1);
        end

        // reset while pair 10 (1,5) is on the outputs
        fr = mk(3, 7);
        load_frame(fr, 0);
        emit_check(fr, 1'b0, 11);
        chk("rst_mid_label_0", x_label_0, 1);
        chk("rst_mid_label_1", x_label_1, 5);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_x_valid", x_valid, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_busy", busy, 0);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_quiet", x_valid, 0);
        end
        fr = mk(100, 1);
        load_frame(fr, 0);
        emit_check(fr, 1'b0, NUM_PAIRS);

        // a partial frame cut by reset must not leak into the next one
        fr = mk(200, 3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = fr[k];
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        fr = mk(40, 5);
        load_frame(fr, 0);
        emit_check(fr, 1'b0, NUM_PAIRS);

        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++) fr[k] = 8'($urandom);
            load_frame(fr, 2);
            emit_check(fr, 1'($urandom_range(0, 1)), NUM_PAIRS);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
